// File: rtl/packed_unpack_pkg.sv
// Shared types for the packed-struct unpacker: FSM states, the default
// two-member signed word layout, and a helper for the member-index width.
package packed_unpack_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Default word: m0 is declared first and therefore occupies the MSBs.
  typedef struct packed signed {
    bit [3:0] m0;
    bit [3:0] m1;
  } word_t;

  localparam int unsigned DEF_FIELD_W = 4;
  localparam int unsigned DEF_NFIELDS = $bits(word_t) / DEF_FIELD_W;

  // Keeps the member-index port at least one bit wide when only one member exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packed_struct_unpacker.sv
// Captures a packed signed word and presents its members one per beat, first-declared first.
// Build option: define UNPACK_SIGN_EXT_EN to sign-extend members into out_ext (default: zero-extend).
module packed_struct_unpacker
  import packed_unpack_pkg::*;
#(
  parameter int unsigned FIELD_W = DEF_FIELD_W,
  parameter int unsigned NFIELDS = DEF_NFIELDS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic        [FIELD_W*NFIELDS-1:0]        in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic        [FIELD_W-1:0]                out_field,
  output logic        [FIELD_W*NFIELDS-1:0]        out_ext,
  output logic signed [FIELD_W*NFIELDS-1:0]        out_word,
  output logic        [idx_width(NFIELDS)-1:0]     out_idx,
  output logic                                     out_last,
  output logic                                     ERROR
);

  localparam int unsigned W     = FIELD_W * NFIELDS;
  localparam int unsigned IDX_W = idx_width(NFIELDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFIELDS - 1);

  state_t           r_state;
  logic [W-1:0]     r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_error;
  logic             r_prev_stall;
  logic [W-1:0]     r_prev_data;

  logic             w_emit;
  logic             w_last;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_err_evt;
  logic [W-1:0]     w_shifted;
  logic [FIELD_W-1:0] w_field;
  logic [W-1:0]     w_ext;

  // Handshake decode; input is accepted on the last beat so a new word follows with no bubble.
  assign w_emit     = (r_state == S_EMIT);
  assign w_last     = w_emit && (r_idx == LAST_IDX);
  assign w_in_ready = !w_emit || (w_last && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_err_evt  = r_prev_stall && (!in_valid || (in_data != r_prev_data));

  // Member idx sits idx*FIELD_W bits below the MSB.
  assign w_shifted = r_word << (32'(r_idx) * FIELD_W);
  assign w_field   = w_shifted[W-1 -: FIELD_W];

`ifdef UNPACK_SIGN_EXT_EN
  assign w_ext = W'($signed(w_field));
`else
  assign w_ext = W'(w_field);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_error      <= 1'b0;
      r_prev_stall <= 1'b0;
      r_prev_data  <= '0;
    end else begin
      r_prev_stall <= in_valid && !w_in_ready;
      r_prev_data  <= in_data;
      if (w_err_evt) begin
        r_error <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word  <= in_data;
            r_idx   <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (!w_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end else if (in_valid) begin
              r_word <= in_data;
              r_idx  <= '0;
            end else begin
              r_idx   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data outputs read as zero whenever no member is being presented.
  assign in_ready  = w_in_ready;
  assign out_valid = w_emit;
  assign out_field = w_emit ? w_field : '0;
  assign out_ext   = w_emit ? w_ext : '0;
  assign out_word  = w_emit ? $signed(r_word) : '0;
  assign out_idx   = w_emit ? r_idx : '0;
  assign out_last  = w_last;
  assign ERROR     = r_error;

endmodule

// File: doc/packed_struct_unpacker.md
PACKED_STRUCT_UNPACKER -- requirements
Module: packed_struct_unpacker

Interface
REQ-001 SHALL have parameter FIELD_W, default 4: width of one packed struct member in bits.
REQ-002 SHALL have parameter NFIELDS, default 2: number of members per packed word; W = FIELD_W*NFIELDS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream packed word valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  W  packed signed word; member 0 = first-declared = MSBs [W-1:W-FIELD_W].
REQ-008 SHALL have port out_valid  output  1  out_field holds a valid member.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the current member.
REQ-010 SHALL have port out_field  output  FIELD_W  raw bits of the current member.
REQ-011 SHALL have port out_ext  output  W  current member extended to W bits, signedness per REQ-029/030.
REQ-012 SHALL have port out_word  output  W  whole captured word, interpreted as signed.
REQ-013 SHALL have port out_idx  output  clog2(NFIELDS)  declaration index of current member.
REQ-014 SHALL have port out_last  output  1  current member is index NFIELDS-1.
REQ-015 SHALL have port ERROR  output  1  sticky upstream-protocol violation flag.

Function
REQ-016 SHALL implement FSM states S_IDLE (empty) and S_EMIT (holding a word, presenting members).
REQ-017 SHALL assert in_ready in S_IDLE, and in S_EMIT only when out_last && out_ready (last-beat handoff).
REQ-018 SHALL, on in_valid && in_ready, capture in_data into the word register, set idx=0, enter/stay in S_EMIT.
REQ-019 SHALL assert out_valid exactly in S_EMIT; out_field = word[W-1-idx*FIELD_W -: FIELD_W].
REQ-020 SHALL, on out_valid && out_ready with !out_last, increment idx; outputs stable otherwise.
REQ-021 SHALL, on last-beat transfer without a concurrent input accept, return to S_IDLE.
REQ-022 SHALL, on last-beat transfer with concurrent input accept, load the new word, stay in S_EMIT, idx=0 (zero bubbles; NFIELDS beats per word sustained).
REQ-023 SHALL present the first member one cycle after input accept (latency 1).
REQ-024 SHALL hold out_word constant from capture until the next capture.
REQ-025 SHALL set ERROR when in_valid was high and in_ready low in the previous cycle and in_valid drops or in_data changes this cycle; ERROR clears only on reset.
REQ-026 SHALL drive out_field/out_ext/out_word/out_idx/out_last to 0 in S_IDLE.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter S_IDLE, clear word, idx and ERROR; next cycle in_ready=1, out_valid=0, ERROR=0, all data outputs 0.
REQ-028 SHALL discard a partially emitted word on reset mid-S_EMIT with no further beats of it; rst has priority over any simultaneous handshake.

Configuration
REQ-029 SHALL, with macro UNPACK_SIGN_EXT_EN defined, sign-extend out_field into out_ext (bit FIELD_W-1 replicated).
REQ-030 SHALL, without UNPACK_SIGN_EXT_EN, zero-extend out_field into out_ext; out_word remains signed in both builds.

Structure
REQ-031 SHALL place typedef state_t {S_IDLE, S_EMIT} and the default word typedef (packed signed struct of two 4-bit bit members) in package packed_unpack_pkg.
REQ-032 SHALL be a single module; no sub-module is required.

Verification
REQ-033 SHALL cover: in_data=8'd200 -> beats (idx0,0xC,last0),(idx1,0x8,last1); out_word=-56 (8'hC8); out_ext=-4,-8 with macro, 12,8 without.
REQ-034 SHALL cover: out_ready low 3 cycles on beat 0 of 8'hC8 -> out_field=0xC, idx=0 held stable 3 cycles, in_ready=0 throughout.
REQ-035 SHALL cover: back-to-back 8'hC8 then 8'h37, out_ready=1 -> beats C,8,3,7 on 4 consecutive cycles, in_ready high on beat 8.
REQ-036 SHALL cover: rst pulsed during beat idx1 of 8'hC8 -> next cycle out_valid=0, in_ready=1, out_word=0; no beat 0x8 emitted.
REQ-037 SHALL cover: in_data changes 8'hC8->8'h11 while in_valid=1, in_ready=0 -> ERROR=1 next cycle, sticky until rst.
REQ-038 SHALL cover: in_data=8'h00 and 8'h7F -> beats 0,0 and 7,F; out_word=0 and +127.
